ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xF4 "enable data reporting") to the mouse over the shared ps2c/ps2d open-drain lines. It sits beside the mouse receiver under the mouse controller and owns the lines only while a frame is in flight. It implements request-to-send inhibit, the device-clocked 11-bit frame, ack check and a watchdog.

## Interface
- INHIBIT_CYCLES, 5000: clk cycles ps2c is held low for request-to-send (100 µs at 50 MHz).
- FILTER_LEN, 8: consecutive equal ps2c samples needed to change the filtered level.
- TIMEOUT_CYCLES, 1_000_000: abort limit counted from entry to START (20 ms at 50 MHz).
- clk  input  1  system clock; one clock domain.
- reset  input  1  asynchronous, active-high reset.
- wr_ps2  input  1  one-cycle start strobe; honoured only while tx_idle=1.
- din  input  8  command byte; captured on the accepted wr_ps2 cycle.
- ps2c  inout  1  PS/2 clock; driven 0 or released (z), never driven 1.
- ps2d  inout  1  PS/2 data; driven 0 or released (z), never driven 1.
- tx_idle  output  1  1 when in IDLE; the receiver may run only then.
- tx_done_tick  output  1  one-cycle pulse at frame end (success or failure).
- ack_err  output  1  1 if the last frame had no device ack or timed out; cleared on the next accepted wr_ps2.

## Operation
- Filter: ps2c is sampled into a FILTER_LEN shift register. The filtered level goes to 1 when all bits are 1 and to 0 when all bits are 0; otherwise it holds. fall is a one-cycle tick on a filtered 1→0 transition.
- Frame register: {odd parity = ~^din, din}, 9 bits, shifted out LSB first.
- FSM states:
  - IDLE: lines released. On wr_ps2, load the frame and the bit counter (9), clear ack_err, go to RTS.
  - RTS: ps2c driven 0 for INHIBIT_CYCLES cycles, then go to START.
  - START: ps2c released, ps2d driven 0 (start bit). On fall, go to DATA.
  - DATA: ps2d driven 0 when frame[0]=0, released when 1. On fall, shift right and decrement the counter. When the counter reaches 0, go to STOP.
  - STOP: ps2d released (stop bit 1). On fall, go to ACK.
  - ACK: lines released. On fall, sample ps2d: 0 means ack OK, 1 means ack_err=1. Go to DONE.
  - DONE: pulse tx_done_tick for one cycle, then go to IDLE.
- Watchdog: counter cleared on entry to START, counts in START/DATA/STOP/ACK. Reaching TIMEOUT_CYCLES releases both lines, sets ack_err=1 and goes to DONE.
- wr_ps2 outside IDLE is ignored; din changes outside IDLE have no effect.
- A fall seen in RTS is ignored, because the host is driving the clock.

## Timing
- Reset values:
  - state IDLE, both lines released.
  - tx_idle=1, tx_done_tick=0, ack_err=0.
  - filter register all 1s, counters 0.
- Reset asserted mid-frame releases both lines combinationally from the asynchronous reset, in the same cycle.
- wr_ps2 at cycle 0 gives tx_idle=0 and ps2c driven low from cycle 1. ps2c stays low exactly INHIBIT_CYCLES cycles.
- ps2d goes low in the same cycle ps2c is released: START entry, RTS→START.
- The filter delays fall by FILTER_LEN+1 clk cycles after the physical edge. Data updates within 1 cycle of fall, well inside the device's half-period of at least 30 µs.
- tx_done_tick is asserted the cycle after the ACK-state fall or the timeout. tx_idle returns to 1 the following cycle.
- Outputs are registered. Tri-state enables are derived from registered state and frame bit only.

## Structure
- Shared package ps2_pkg:
  - FSM state encoding.
  - command constants: CMD_ENABLE=8'hF4, CMD_RESET=8'hFF, CMD_SET_DEFAULTS=8'hF6.
  - odd-parity function.
- Sub-module ps2_clk_filter: synchroniser, FILTER_LEN filter and fall tick. Reused by the receiver so both ends see identical edges.
- Top-level ownership:
  - mouse controller gates its receiver with tx_idle.
  - mouse controller issues CMD_ENABLE once after reset.

## Test plan
- Nominal frame: din=0xF4, device model clocks at 12.5 kHz and acks with data low. Required:
  - ps2c low for 5000 cycles.
  - ps2d sequence 0 | 0,0,1,0,1,1,1,1 | parity 0 | 1.
  - tx_done_tick once, ack_err=0.
- Parity check: din=0xFF. Required: parity bit 1 (data bits all 1), ack OK.
- Missing ack: din=0x00, device leaves ps2d high at ack. Required:
  - parity bit 1.
  - ack_err=1, tx_done_tick pulse.
  - ack_err cleared by the next wr_ps2.
- Silent device: wr_ps2 with no device clocks. Required:
  - timeout after exactly 1_000_000 cycles in START.
  - lines released, ack_err=1, tx_idle=1 two cycles later.
- Glitch and busy handling:
  - ps2c glitch of 3 cycles low during DATA is ignored, with no shift.
  - a second wr_ps2 during DATA is ignored and the frame completes unchanged.
- Reset mid-DATA (bit 4): both lines released in the same cycle, outputs at reset values, and a new 0xF6 frame afterwards completes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, mouse command bytes
// and the frame parity helper used by both the host transmitter and receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RTS,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_ACK,
        ST_DONE
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_ENABLE       = 8'hF4;
    localparam logic [7:0] CMD_RESET        = 8'hFF;
    localparam logic [7:0] CMD_SET_DEFAULTS = 8'hF6;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_filter.sv
// PS/2 clock conditioner: the shift register doubles as synchroniser, the
// level changes only after FILTER_LEN equal samples, fall ticks on 1->0.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_ps2c,
    output logic o_fall
);

    logic [FILTER_LEN-1:0] r_sh;
    logic                  r_level;
    logic                  r_fall;
    logic                  w_all1;
    logic                  w_all0;

    assign w_all1 = &r_sh;
    assign w_all0 = ~|r_sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh    <= '1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_sh   <= {r_sh[FILTER_LEN-2:0], i_ps2c};
            r_fall <= r_level & w_all0;
            if (w_all1) begin
                r_level <= 1'b1;
            end else if (w_all0) begin
                r_level <= 1'b0;
            end
        end
    end

    assign o_fall = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send inhibit, device-clocked
// 11-bit frame, ack check and watchdog. Lines are only ever pulled low.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                             INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t r_state;
    ps2_tx_state_t w_state_nx;
    logic [8:0]    r_frame;
    logic [8:0]    w_frame_nx;
    logic [3:0]    r_bits;
    logic [3:0]    w_bits_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic          r_ack_err;
    logic          w_ack_err_nx;
    logic [1:0]    r_dsync;
    logic          w_fall;
    logic          w_wd_active;
    logic          w_c_low;
    logic          w_d_low;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk    (clk),
        .reset  (reset),
        .i_ps2c (ps2c),
        .o_fall (w_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_frame   <= '0;
            r_bits    <= '0;
            r_cnt     <= '0;
            r_ack_err <= 1'b0;
            r_dsync   <= 2'b11;
        end else begin
            r_state   <= w_state_nx;
            r_frame   <= w_frame_nx;
            r_bits    <= w_bits_nx;
            r_cnt     <= w_cnt_nx;
            r_ack_err <= w_ack_err_nx;
            r_dsync   <= {r_dsync[0], ps2d};
        end
    end

    assign w_wd_active = (r_state == ST_START) || (r_state == ST_DATA) ||
                         (r_state == ST_STOP)  || (r_state == ST_ACK);

    always_comb begin
        w_state_nx   = r_state;
        w_frame_nx   = r_frame;
        w_bits_nx    = r_bits;
        w_cnt_nx     = r_cnt;
        w_ack_err_nx = r_ack_err;
        unique case (r_state)
            ST_IDLE: begin
                if (wr_ps2) begin
                    w_frame_nx   = {odd_parity(din), din};
                    w_bits_nx    = 4'd9;
                    w_cnt_nx     = '0;
                    w_ack_err_nx = 1'b0;
                    w_state_nx   = ST_RTS;
                end
            end
            ST_RTS: begin
                if (r_cnt == INH_LAST) begin
                    w_cnt_nx   = '0;
                    w_state_nx = ST_START;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            ST_START: begin
                if (w_fall) begin
                    w_state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_fall) begin
                    w_frame_nx = {1'b0, r_frame[8:1]};
                    w_bits_nx  = r_bits - 1'b1;
                    if (r_bits == 4'd1) begin
                        w_state_nx = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (w_fall) begin
                    w_state_nx = ST_ACK;
                end
            end
            ST_ACK: begin
                if (w_fall) begin
                    w_ack_err_nx = r_dsync[1];
                    w_state_nx   = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
        // Watchdog overrides any frame progress once the device stalls.
        if (w_wd_active) begin
            if (r_cnt == TO_LAST) begin
                w_ack_err_nx = 1'b1;
                w_state_nx   = ST_DONE;
            end else begin
                w_cnt_nx = r_cnt + 1'b1;
            end
        end
    end

    assign w_c_low = (r_state == ST_RTS) & ~reset;
    assign w_d_low = ((r_state == ST_START) |
                      ((r_state == ST_DATA) & ~r_frame[0])) & ~reset;

    assign ps2c = w_c_low ? 1'b0 : 1'bz;
    assign ps2d = w_d_low ? 1'b0 : 1'bz;

    assign tx_idle      = (r_state == ST_IDLE);
    assign tx_done_tick = (r_state == ST_DONE);
    assign ack_err      = r_ack_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with pull-ups, a clocking mouse
// model, and a cycle model of idle/ack_err/line-release behaviour.
module tb_ps2_host_tx;

    localparam int INH = 50;
    localparam int FL  = 8;
    localparam int TO  = 3000;
    localparam int H   = 40;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din    = 8'h00;
    wire        ps2c;
    wire        ps2d;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       ack_err;
    logic       dev_c  = 1'b0;
    logic       dev_d  = 1'b0;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c ? 1'b0 : 1'bz;
    assign ps2d = dev_d ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .ack_err      (ack_err)
    );

    int n_vec  = 0;
    int n_bad  = 0;
    int n_done = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic expire(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // Line sequence the device must observe: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = d[i];
            ones  += int'(d[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    logic m_idle      = 1'b1;
    logic m_err       = 1'b0;
    logic m_frame_err = 1'b0;
    logic p_done      = 1'b0;
    logic chk_en      = 1'b1;
    int   rts_run     = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_idle  = 1'b1;
            m_err   = 1'b0;
            p_done  = 1'b0;
            rts_run = 0;
        end else begin
            if (p_done) begin
                m_idle = 1'b1;
                p_done = 1'b0;
            end else if (wr_ps2 && m_idle) begin
                m_idle = 1'b0;
                m_err  = 1'b0;
            end
            #1;
            if (chk_en && !reset) begin
                chk("tx_idle", tx_idle, m_idle);
                if (tx_done_tick) begin
                    n_done++;
                    chk("done_while_idle", m_idle, 0);
                    m_err  = m_frame_err;
                    p_done = 1'b1;
                end
                chk("ack_err", ack_err, m_err);
                if (ps2c === 1'b0 && !dev_c) begin
                    rts_run++;
                end else if (rts_run > 0) begin
                    chk("rts_len", rts_run, INH);
                    rts_run = 0;
                end
                if (m_idle) begin
                    chk("c_released", ps2c | dev_c, 1);
                    chk("d_released", ps2d | dev_d, 1);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        din    = d;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
    endtask

    task automatic dev_frame(input int npulse, input bit ack, input int glitch_k,
                             output logic [10:0] bits);
        int t;
        t    = 0;
        bits = '0;
        while (!(ps2c === 1'b1 && ps2d === 1'b0) && t < INH + 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= INH + 200) begin
            expire("start_wait");
            return;
        end
        repeat (30) @(negedge clk);
        for (int k = 0; k < npulse; k++) begin
            if (k < 11) bits[k] = ps2d;
            dev_c = 1'b1;
            repeat (H) @(negedge clk);
            dev_c = 1'b0;
            if (k == 10 && ack) dev_d = 1'b1;
            if (k == 11) dev_d = 1'b0;
            if (k == glitch_k) begin
                repeat (H / 2) @(negedge clk);
                dev_c = 1'b1;
                repeat (3) @(negedge clk);
                dev_c = 1'b0;
                repeat (H - H / 2 - 3) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
    endtask

    task automatic run_frame(input string nm, input logic [7:0] d, input bit ack,
                             input int glitch_k, input logic [10:0] pin);
        logic [10:0] bits;
        int d0;
        int t;
        d0 = n_done;
        t  = 0;
        m_frame_err = !ack;
        chk({nm, "_model"}, int'(frame_bits(d)), int'(pin));
        send(d);
        dev_frame(12, ack, glitch_k, bits);
        chk({nm, "_bits"}, int'(bits), int'(frame_bits(d)));
        while (!tx_idle && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) expire({nm, "_idle_wait"});
        repeat (2) @(negedge clk);
        chk({nm, "_ndone"}, n_done - d0, 1);
        chk({nm, "_ackerr"}, ack_err, int'(!ack));
    endtask

    initial begin
        logic [10:0] bits;
        int t;

        repeat (3) @(negedge clk);
        chk("rst_idle", tx_idle, 1);
        chk("rst_done", tx_done_tick, 0);
        chk("rst_ackerr", ack_err, 0);
        chk("rst_c", ps2c, 1);
        chk("rst_d", ps2d, 1);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        run_frame("enable", ps2_pkg::CMD_ENABLE, 1'b1, -1, 11'h5E8);
        run_frame("par_ff", ps2_pkg::CMD_RESET, 1'b1, -1, 11'h7FE);
        run_frame("noack", 8'h00, 1'b0, -1, 11'h600);

        m_frame_err = 1'b1;
        send(8'h55);
        chk("ack_clr", ack_err, 0);
        t = 0;
        while (ps2d !== 1'b0 && t < INH + 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= INH + 100) expire("silent_start");
        t = 0;
        while (!tx_done_tick && t < TO + 100) begin
            @(negedge clk);
            t++;
        end
        chk("timeout_len", t, TO);
        chk("timeout_c", ps2c, 1);
        chk("timeout_d", ps2d, 1);
        chk("timeout_err", ack_err, 1);
        @(negedge clk);
        chk("timeout_idle", tx_idle, 1);
        repeat (3) @(negedge clk);

        fork
            run_frame("glitch_busy", 8'hA5, 1'b1, 3, 11'h74A);
            begin
                repeat (400) @(negedge clk);
                din    = 8'h00;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
            end
        join

        m_frame_err = 1'b0;
        send(8'h0F);
        dev_frame(5, 1'b0, -1, bits);
        chk("mid_bits", int'(bits[4:0]), 5'b11110);
        chk("mid_d_low", ps2d, 0);
        chk_en = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_c", ps2c, 1);
        chk("arst_d", ps2d, 1);
        chk("arst_idle", tx_idle, 1);
        chk("arst_done", tx_done_tick, 0);
        chk("arst_ackerr", ack_err, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        run_frame("defaults", ps2_pkg::CMD_SET_DEFAULTS, 1'b1, -1, 11'h7EC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
